// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The loader takes the slave side; byte source and memory sit on the master side.
interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, we, wa, wd
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, we, wa, wd
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: packs a byte stream into little-endian 32-bit words,
// writes them to consecutive word addresses and holds the CPU while loading.
module imem_loader #(
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] word_count,
    imem_loader_if.slave  bus,
    output logic          busy,
    output logic          cpu_hold,
    output logic          done,
    output logic [31:0]   checksum
);
    localparam int IW = CW - 1;

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] count;
    logic [IW-1:0] word_idx;
    logic [1:0]    byte_idx;
    logic [23:0]   word_lo;
    logic [31:0]   wa_q;
    logic [31:0]   wd_q;
    logic          last_word;

    function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] n);
        if (n > CW'(DEPTH))
            return CW'(DEPTH);
        return n;
    endfunction

    // Only lanes 0..2 are buffered; lane 3 is merged straight into wd.
    function automatic logic [23:0] insert_byte(input logic [23:0] w,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  b);
        logic [23:0] r;
        r = w;
        case (lane)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            default: r[23:16] = b;
        endcase
        return r;
    endfunction

    assign last_word = ({1'b0, word_idx} == (count - 1'b1));

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.byte_ready = 1'b0;
        bus.we         = 1'b0;
        done           = 1'b0;
        busy           = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    state_nxt = (clamp_count(word_count) == '0) ? DONE : RECV;
            end
            RECV: begin
                bus.byte_ready = 1'b1;
                if (bus.byte_valid && (byte_idx == 2'd3))
                    state_nxt = WRITE;
            end
            WRITE: begin
                bus.we    = 1'b1;
                state_nxt = last_word ? DONE : RECV;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cpu_hold = busy;
    assign bus.wa   = wa_q;
    assign bus.wd   = wd_q;

    // Visible outputs: cleared by reset, otherwise hold between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wa_q     <= '0;
            wd_q     <= '0;
            checksum <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start)
                        checksum <= '0;
                end
                RECV: begin
                    if (bus.byte_valid && (byte_idx == 2'd3)) begin
                        wd_q <= {bus.byte_data, word_lo};
                        wa_q <= {{(30-IW){1'b0}}, word_idx, 2'b00};
                    end
                end
                WRITE: checksum <= checksum ^ wd_q;
                default: ;
            endcase
        end
    end

    // Load bookkeeping; every load re-initialises it on start, so no reset needed.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start) begin
                    count    <= clamp_count(word_count);
                    word_idx <= '0;
                    byte_idx <= '0;
                    word_lo  <= '0;
                end
            end
            RECV: begin
                if (bus.byte_valid) begin
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx != 2'd3)
                        word_lo <= insert_byte(word_lo, byte_idx, bus.byte_data);
                end
            end
            WRITE: begin
                byte_idx <= '0;
                if (!last_word)
                    word_idx <= word_idx + 1'b1;
            end
            default: ;
        endcase
    end
endmodule
